// File: rtl/dmem_bridge_pkg.sv
// dmem_bridge_pkg: shared definitions for the data-memory bridge.
//   - FSM state codes (legacy localparam encodings) and the state enum built on them
//   - ERR_RDATA_DEFAULT: read data returned when a transaction times out
//   - ADDR_ALIGN_MASK: clears byte-offset bits to form a word-aligned bus address
//   - CNT_W: width of the timeout counters (TIMEOUT up to 255 plus headroom)
package dmem_bridge_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_REQ  = S_REQ,
        ST_WAIT = S_WAIT,
        ST_DONE = S_DONE
    } state_t;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] ADDR_ALIGN_MASK   = 32'hFFFF_FFFC;

    localparam int unsigned CNT_W = 9;

endpackage

// File: rtl/dmem_wbuf.sv
// dmem_wbuf: one-entry posted-write buffer that drains a store to the bus.
// Used by dmem_bridge only when DMEM_BRIDGE_POSTED_WR_EN is defined.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   load                   capture load_addr/load_wdata (only when not busy)
//   load_addr, load_wdata  store to buffer; address is word-aligned on capture
//   busy                   buffer holds a store; doubles as bus_req for the drain
//   bus_addr, bus_wdata    buffered store, stable while busy
//   bus_gnt                bus accepted the drain this cycle
//   drop                   one-cycle pulse when the drain timed out and the store was discarded
module dmem_wbuf
    import dmem_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_wdata,
    output logic        busy,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    output logic        drop
);

    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);

    logic             busy_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [CNT_W-1:0] cnt_q;
    logic             drop_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            drop_q <= 1'b0;
            if (load) begin
                busy_q  <= 1'b1;
                addr_q  <= load_addr & ADDR_ALIGN_MASK;
                wdata_q <= load_wdata;
                cnt_q   <= '0;
            end else if (busy_q) begin
                if (bus_gnt) begin
                    busy_q <= 1'b0;
                end else if (cnt_q >= TO_LIMIT) begin
                    busy_q <= 1'b0;
                    drop_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign busy      = busy_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign drop      = drop_q;

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: converts CPU memory-stage load/store requests into a
// request/grant bus handshake with read-data return and timeout abort.
// Optional feature: define DMEM_BRIDGE_POSTED_WR_EN to post stores through a
// one-entry write buffer (dmem_wbuf); stores then complete the cycle after capture.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   cpu_req/cpu_addr/cpu_write/cpu_wdata  CPU request, held until cpu_valid
//   cpu_valid, cpu_rdata, cpu_err     completion pulse, load data, timeout flag
//   bus_req/bus_we/bus_addr/bus_wdata bus request, stable while bus_req=1
//   bus_gnt                           bus accepts the request in the bus_req cycle
//   bus_rvalid, bus_rdata             read data return
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 64,
    parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_write,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_valid,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);

    state_t           state;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      addr_q;
    logic             we_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q;
    logic             err_q;

    logic             idle_ok;    // a new request may be captured this IDLE cycle
    logic             wr_posted;  // the request being captured completes without the bus FSM

`ifdef DMEM_BRIDGE_POSTED_WR_EN
    logic        wb_load;
    logic        wb_busy;
    logic [31:0] wb_addr;
    logic [31:0] wb_wdata;
    logic        wb_drop;

    // Any request waits for the buffer to drain so bus order matches program order.
    assign idle_ok   = !wb_busy;
    assign wr_posted = cpu_write;
    assign wb_load   = (state == ST_IDLE) && cpu_req && cpu_write && !wb_busy;

    dmem_wbuf #(
        .TIMEOUT (TIMEOUT)
    ) u_wbuf (
        .clk        (clk),
        .rst        (rst),
        .load       (wb_load),
        .load_addr  (cpu_addr),
        .load_wdata (cpu_wdata),
        .busy       (wb_busy),
        .bus_addr   (wb_addr),
        .bus_wdata  (wb_wdata),
        .bus_gnt    (bus_gnt),
        .drop       (wb_drop)
    );
`else
    assign idle_ok   = 1'b1;
    assign wr_posted = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu_req && idle_ok) begin
                        addr_q  <= cpu_addr & ADDR_ALIGN_MASK;
                        we_q    <= cpu_write;
                        wdata_q <= cpu_wdata;
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                        cnt_q   <= '0;
                        state   <= (wr_posted && cpu_write) ? ST_DONE : ST_REQ;
                    end
                end
                ST_REQ: begin
                    // A grant in the limit cycle still wins: the bus has taken the request.
                    if (bus_gnt) begin
                        cnt_q <= cnt_q + 1'b1;
                        state <= we_q ? ST_DONE : ST_WAIT;
                    end else if (cnt_q >= TO_LIMIT) begin
                        rdata_q <= ERR_RDATA;
                        err_q   <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (bus_rvalid) begin
                        rdata_q <= bus_rdata;
                        state   <= ST_DONE;
                    end else if (cnt_q >= TO_LIMIT) begin
                        rdata_q <= ERR_RDATA;
                        err_q   <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cpu_valid = (state == ST_DONE);
    assign cpu_rdata = rdata_q;

`ifdef DMEM_BRIDGE_POSTED_WR_EN
    assign cpu_err   = ((state == ST_DONE) && err_q) || wb_drop;
    assign bus_req   = wb_busy || (state == ST_REQ);
    assign bus_we    = wb_busy ? 1'b1     : we_q;
    assign bus_addr  = wb_busy ? wb_addr  : addr_q;
    assign bus_wdata = wb_busy ? wb_wdata : wdata_q;
`else
    assign cpu_err   = (state == ST_DONE) && err_q;
    assign bus_req   = (state == ST_REQ);
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
`endif

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed bench for dmem_bridge (TIMEOUT=8, default ERR_RDATA).
// Cycle N is the cycle in which cpu_req is first driven; cycle N+k is observed
// at the negative edge k clock periods later.
module tb_dmem_bridge;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        cpu_write;
    logic [31:0] cpu_wdata;
    logic        cpu_valid;
    logic [31:0] cpu_rdata;
    logic        cpu_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int total = 0;
    int bad   = 0;

    dmem_bridge #(
        .TIMEOUT   (8),
        .ERR_RDATA (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_write  (cpu_write),
        .cpu_wdata  (cpu_wdata),
        .cpu_valid  (cpu_valid),
        .cpu_rdata  (cpu_rdata),
        .cpu_err    (cpu_err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        rst = 1'b1; cpu_req = 1'b1; cpu_write = 1'b1;
        cpu_addr = 32'hFFFF_FFFF; cpu_wdata = 32'hFFFF_FFFF;
        bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (cpu_valid !== 1'b0) begin bad++; $display("FAIL rst_cpu_valid: got %b expected 0", cpu_valid); end
        total++; if (cpu_err !== 1'b0) begin bad++; $display("FAIL rst_cpu_err: got %b expected 0", cpu_err); end
        total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL rst_cpu_rdata: got %h expected 0", cpu_rdata); end
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL rst_bus_req: got %b expected 0", bus_req); end
        total++; if (bus_we !== 1'b0) begin bad++; $display("FAIL rst_bus_we: got %b expected 0", bus_we); end
        total++; if (bus_addr !== 32'h0) begin bad++; $display("FAIL rst_bus_addr: got %h expected 0", bus_addr); end
        total++; if (bus_wdata !== 32'h0) begin bad++; $display("FAIL rst_bus_wdata: got %h expected 0", bus_wdata); end
        @(posedge clk); #1;
        rst = 1'b0; cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        @(posedge clk); #1;
    endtask

    // Read: grant in N+1, rvalid in N+2 -> cpu_valid in N+3.
    task automatic test_read(input logic [31:0] data);
        int vcyc = -1;
        int pulses = 0;
        logic [31:0] rd = '0;
        logic breq1 = 1'b0;
        logic [31:0] baddr1 = '0;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h0000_2006; cpu_wdata = 32'hFFFF_FFFF;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (pulses != 0) cpu_req = 1'b0;
            bus_gnt = (k == 1);
            bus_rvalid = (k == 2);
            bus_rdata = (k == 2) ? data : 32'h1111_1111;
            @(negedge clk);
            if (k == 1) begin breq1 = bus_req; baddr1 = bus_addr; end
            if (cpu_valid) begin
                pulses++;
                if (vcyc < 0) begin vcyc = k; rd = cpu_rdata; end
            end
        end
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        total++; if (breq1 !== 1'b1) begin bad++; $display("FAIL read_bus_req_n1: got %b expected 1", breq1); end
        total++; if (baddr1 !== 32'h0000_2004) begin bad++; $display("FAIL read_bus_addr: got %h expected 00002004", baddr1); end
        total++; if (vcyc != 3) begin bad++; $display("FAIL read_valid_cycle: got %0d expected 3", vcyc); end
        total++; if (pulses != 1) begin bad++; $display("FAIL read_valid_pulses: got %0d expected 1", pulses); end
        total++; if (rd !== data) begin bad++; $display("FAIL read_rdata: got %h expected %h", rd, data); end
    endtask

    // Write to unaligned address, grant in N+4.
    task automatic test_write_delayed();
        int vcyc = -1;
        int pulses = 0;
        int reqc = 0;
        int exp_v;
        logic [31:0] rd = 32'hFFFF_FFFF;
`ifdef DMEM_BRIDGE_POSTED_WR_EN
        exp_v = 1;
`else
        exp_v = 5;
`endif
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_write = 1'b1; cpu_addr = 32'h0000_1003; cpu_wdata = 32'h1234_5678;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (pulses != 0) cpu_req = 1'b0;
            bus_gnt = (k == 4);
            @(negedge clk);
            if (bus_req) begin
                reqc++;
                total++; if (bus_addr !== 32'h0000_1000) begin bad++; $display("FAIL write_bus_addr c%0d: got %h expected 00001000", k, bus_addr); end
                total++; if (bus_we !== 1'b1) begin bad++; $display("FAIL write_bus_we c%0d: got %b expected 1", k, bus_we); end
                total++; if (bus_wdata !== 32'h1234_5678) begin bad++; $display("FAIL write_bus_wdata c%0d: got %h expected 12345678", k, bus_wdata); end
            end
            if (cpu_valid) begin
                pulses++;
                if (vcyc < 0) begin vcyc = k; rd = cpu_rdata; end
            end
        end
        bus_gnt = 1'b0; cpu_write = 1'b0;
        total++; if (reqc != 4) begin bad++; $display("FAIL write_req_cycles: got %0d expected 4", reqc); end
        total++; if (vcyc != exp_v) begin bad++; $display("FAIL write_valid_cycle: got %0d expected %0d", vcyc, exp_v); end
        total++; if (pulses != 1) begin bad++; $display("FAIL write_valid_pulses: got %0d expected 1", pulses); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL write_rdata: got %h expected 0", rd); end
    endtask

    // Read with no bus response; spurious rvalid while in REQ must be ignored.
    task automatic test_timeout();
        int vcyc = -1;
        int pulses = 0;
        int errs = 0;
        int reqc = 0;
        int late_req = 0;
        logic verr = 1'b0;
        logic [31:0] rd = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h0000_0040;
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk); #1;
            if (pulses != 0) cpu_req = 1'b0;
            bus_rvalid = (k == 2);
            bus_rdata = (k == 2) ? 32'hDEAD_0001 : 32'h0;
            @(negedge clk);
            if (bus_req) begin
                if (k >= 10) late_req++; else reqc++;
            end
            if (cpu_err) errs++;
            if (cpu_valid) begin
                pulses++;
                if (vcyc < 0) begin vcyc = k; rd = cpu_rdata; verr = cpu_err; end
            end
        end
        bus_rvalid = 1'b0;
        total++; if (reqc != 9) begin bad++; $display("FAIL timeout_req_cycles: got %0d expected 9", reqc); end
        total++; if (vcyc != 10) begin bad++; $display("FAIL timeout_valid_cycle: got %0d expected 10", vcyc); end
        total++; if (verr !== 1'b1) begin bad++; $display("FAIL timeout_err_with_valid: got %b expected 1", verr); end
        total++; if (errs != 1) begin bad++; $display("FAIL timeout_err_pulses: got %0d expected 1", errs); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL timeout_rdata: got %h expected 0", rd); end
        total++; if (late_req != 0) begin bad++; $display("FAIL timeout_bus_req_after: got %0d expected 0", late_req); end
        total++; if (pulses != 1) begin bad++; $display("FAIL timeout_valid_pulses: got %0d expected 1", pulses); end
    endtask

    // Two reads with cpu_req held; spurious rvalid in the IDLE cycle between them.
    task automatic test_back_to_back();
        int v1 = -1;
        int v2 = -1;
        int breq2 = -1;
        int pulses = 0;
        logic [31:0] r1 = '0;
        logic [31:0] r2 = '0;
        logic [31:0] a2 = '0;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h0000_0800;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (pulses >= 2) cpu_req = 1'b0;
            if (k == 4) cpu_addr = 32'h0000_3004;
            bus_gnt = (k == 1) || (k == 5);
            bus_rvalid = (k == 2) || (k == 4) || (k == 6);
            bus_rdata = (k == 2) ? 32'hA1A1_0001 : (k == 4) ? 32'hBAD0_BAD0 : (k == 6) ? 32'h5555_AAAA : 32'h0;
            @(negedge clk);
            if (v1 >= 0 && breq2 < 0 && bus_req) begin breq2 = k; a2 = bus_addr; end
            if (cpu_valid) begin
                pulses++;
                if (v1 < 0) begin v1 = k; r1 = cpu_rdata; end
                else if (v2 < 0) begin v2 = k; r2 = cpu_rdata; end
            end
        end
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        total++; if (v1 != 3) begin bad++; $display("FAIL b2b_valid1_cycle: got %0d expected 3", v1); end
        total++; if (r1 !== 32'hA1A1_0001) begin bad++; $display("FAIL b2b_rdata1: got %h expected a1a10001", r1); end
        total++; if (breq2 != 5) begin bad++; $display("FAIL b2b_req2_cycle: got %0d expected 5", breq2); end
        total++; if (a2 !== 32'h0000_3004) begin bad++; $display("FAIL b2b_addr2: got %h expected 00003004", a2); end
        total++; if (v2 != 7) begin bad++; $display("FAIL b2b_valid2_cycle: got %0d expected 7", v2); end
        total++; if (r2 !== 32'h5555_AAAA) begin bad++; $display("FAIL b2b_rdata2: got %h expected 5555aaaa", r2); end
        total++; if (pulses != 2) begin bad++; $display("FAIL b2b_valid_pulses: got %0d expected 2", pulses); end
    endtask

    // Reset while waiting for read data; the abandoned read never completes.
    task automatic test_reset_mid();
        int pulses = 0;
        logic breq4 = 1'b1;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h0000_0100;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            bus_gnt = (k == 1);
            if (k == 3) begin rst = 1'b1; cpu_req = 1'b0; end
            if (k == 4) rst = 1'b0;
            bus_rvalid = (k == 5);
            bus_rdata = (k == 5) ? 32'h7E57_0000 : 32'h0;
            @(negedge clk);
            if (k == 4) breq4 = bus_req;
            if (cpu_valid) pulses++;
        end
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        total++; if (pulses != 0) begin bad++; $display("FAIL rstmid_no_valid: got %0d expected 0", pulses); end
        total++; if (breq4 !== 1'b0) begin bad++; $display("FAIL rstmid_bus_req: got %b expected 0", breq4); end
        test_read(32'h0BAD_CAFE);
    endtask

`ifdef DMEM_BRIDGE_POSTED_WR_EN
    // Posted store then read: store drain granted in N+6, read must follow it.
    task automatic test_posted();
        int v1 = -1;
        int v2 = -1;
        int rreq = -1;
        int wlast = -1;
        int pulses = 0;
        logic rd_pend = 1'b0;
        logic [31:0] r2 = '0;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_write = 1'b1; cpu_addr = 32'h0000_2000; cpu_wdata = 32'h0000_A5A5;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            if (k == 2) begin cpu_write = 1'b0; cpu_addr = 32'h0000_4000; end
            if (pulses >= 2) cpu_req = 1'b0;
            bus_rvalid = rd_pend;
            bus_rdata = rd_pend ? 32'h7777_1234 : 32'h0;
            rd_pend = 1'b0;
            bus_gnt = (k == 6) || (bus_req && !bus_we);
            if (bus_req && !bus_we) rd_pend = 1'b1;
            @(negedge clk);
            if (bus_req && !bus_we && rreq < 0) rreq = k;
            if (bus_req && bus_we) wlast = k;
            if (cpu_valid) begin
                pulses++;
                if (v1 < 0) v1 = k;
                else if (v2 < 0) begin v2 = k; r2 = cpu_rdata; end
            end
        end
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        total++; if (v1 != 1) begin bad++; $display("FAIL posted_wr_valid_cycle: got %0d expected 1", v1); end
        total++; if (wlast != 6) begin bad++; $display("FAIL posted_wr_last_req: got %0d expected 6", wlast); end
        total++; if (rreq <= 6) begin bad++; $display("FAIL posted_rd_req_order: got %0d expected >6", rreq); end
        total++; if (v2 < 0) begin bad++; $display("FAIL posted_rd_valid: got %0d expected completion", v2); end
        total++; if (r2 !== 32'h7777_1234) begin bad++; $display("FAIL posted_rd_rdata: got %h expected 77771234", r2); end
        total++; if (pulses != 2) begin bad++; $display("FAIL posted_valid_pulses: got %0d expected 2", pulses); end
    endtask
`endif

    initial begin
        test_reset();
        test_read(32'hCAFE_F00D);
        test_write_delayed();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
`ifdef DMEM_BRIDGE_POSTED_WR_EN
        test_posted();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter: TIMEOUT, 64, bus cycles allowed in REQ+WAIT before abort (range 2..255).
REQ-002 Parameter: ERR_RDATA, 32'h0000_0000, read data returned on timeout.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 cpu_req  in  1  access request from CPU memory stage; held with stable addr/write/wdata until cpu_valid.
REQ-006 cpu_addr  in  32  byte address.
REQ-007 cpu_write  in  1  1 = store, 0 = load.
REQ-008 cpu_wdata  in  32  store data.
REQ-009 cpu_valid  out  1  one-cycle completion pulse; feeds CPU mem_valid.
REQ-010 cpu_rdata  out  32  load data, valid only while cpu_valid=1.
REQ-011 cpu_err  out  1  one-cycle pulse, coincident with cpu_valid, on timeout.
REQ-012 bus_req  out  1  bus request; held until bus_gnt.
REQ-013 bus_we  out  1  bus write enable.
REQ-014 bus_addr  out  32  bus address, word aligned (bits [1:0] forced 0).
REQ-015 bus_wdata  out  32  bus write data.
REQ-016 bus_gnt  in  1  bus accepts request in the same cycle bus_req=1.
REQ-017 bus_rvalid  in  1  read data valid, at least one cycle after grant.
REQ-018 bus_rdata  in  32  read data.

Function
REQ-019 FSM states IDLE, REQ, WAIT, DONE.
- IDLE: cpu_req=1 -> capture addr/write/wdata into registers, go to REQ.
- REQ: bus_req=1 from registers; bus_gnt & write -> DONE; bus_gnt & read -> WAIT.
- WAIT: bus_rvalid -> capture bus_rdata, DONE.
- DONE: cpu_valid=1 for exactly one cycle, then IDLE unconditionally.
REQ-020 bus_addr/bus_we/bus_wdata SHALL be stable for every cycle bus_req=1.
REQ-021 Minimum latency: cpu_req sampled cycle N, bus_req cycle N+1; write with immediate grant -> cpu_valid N+2; read with grant N+1 and rvalid N+2 -> cpu_valid N+3.
REQ-022 New request not sampled in DONE; earliest next capture is the IDLE cycle after DONE.
REQ-023 bus_rvalid outside WAIT is ignored; bus_gnt outside REQ is ignored.
REQ-024 Timeout counter clears on entry to REQ, increments each REQ/WAIT cycle; on reaching TIMEOUT -> DONE with cpu_rdata=ERR_RDATA, cpu_err=1, bus_req dropped.
REQ-025 cpu_rdata for stores SHALL be 0.
REQ-026 cpu_req deasserting mid-transaction has no effect; the captured transaction completes.

Reset
REQ-027 rst=1 -> IDLE, counter 0, cpu_valid=0, cpu_err=0, cpu_rdata=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0 on the next edge.
REQ-028 Reset mid-transaction abandons it; no cpu_valid is produced for it.

Configuration
REQ-029 Macro DMEM_BRIDGE_POSTED_WR_EN.
- Defined: a store is captured into a one-entry write buffer and cpu_valid pulses the cycle after capture; the buffer drains to the bus in the background; any next request (read or write) waits in IDLE until the buffer is empty, preserving order; buffered-write timeout drops the write and pulses cpu_err alone (cpu_valid=0).
- Undefined: stores complete only on bus_gnt as in REQ-019; no buffer logic.

Structure
REQ-030 Shared package dmem_bridge_pkg: state enum, ERR_RDATA default, address-alignment mask constant.
REQ-031 One sub-module dmem_wbuf (write buffer + drain handshake), instantiated only under DMEM_BRIDGE_POSTED_WR_EN.

Verification
REQ-032 Read, gnt same cycle, rvalid +1, bus_rdata=32'hCAFE_F00D -> cpu_valid at N+3, cpu_rdata=32'hCAFE_F00D, single pulse.
REQ-033 Write addr=32'h0000_1003, gnt delayed 3 cycles -> bus_addr=32'h0000_1000 stable 4 cycles, cpu_valid at N+5.
REQ-034 Read, bus never responds, TIMEOUT=8 -> cpu_valid+cpu_err at N+10, cpu_rdata=0, bus_req low afterwards.
REQ-035 Back-to-back reads with cpu_req held high -> second bus_req no earlier than two cycles after first cpu_valid; spurious bus_rvalid in IDLE ignored.
REQ-036 rst asserted during WAIT -> no cpu_valid; next read completes normally.
REQ-037 With DMEM_BRIDGE_POSTED_WR_EN, write then read, write gnt delayed 5 -> write cpu_valid at N+1; read bus_req only after write granted.
